// File: rtl/cnn_sched_pkg.sv
// Shared types for the spectral-buffer ping-pong scheduler.
// Bank encoding puts "holds valid data" (FULL or DRAINING) in bit 1.
package cnn_sched_pkg;

    localparam int unsigned NBANK = 2;

    typedef enum logic [1:0] {
        BankEmpty    = 2'b00,
        BankFilling  = 2'b01,
        BankFull     = 2'b10,
        BankDraining = 2'b11
    } bank_state_e;

    typedef enum logic [1:0] {
        TopIdle,
        TopRun,
        TopDone
    } top_state_e;

    function automatic logic bank_has_data(bank_state_e s);
        return s[1];
    endfunction

endpackage

// File: rtl/spec_bank_tracker.sv
// Lifecycle of one spectral buffer bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module spec_bank_tracker
    import cnn_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_claim_wr,
    input  logic        i_wr_done,
    input  logic        i_claim_rd,
    input  logic        i_rd_done,
    output bank_state_e o_state
);

    bank_state_e r_state;
    bank_state_e w_state_next;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BankEmpty:    if (i_claim_wr) w_state_next = BankFilling;
            BankFilling:  if (i_wr_done)  w_state_next = BankFull;
            BankFull:     if (i_claim_rd) w_state_next = BankDraining;
            BankDraining: if (i_rd_done)  w_state_next = BankEmpty;
            default:                      w_state_next = BankEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= BankEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/ifft_bank_sched.sv
// Ping-pong scheduler: hands an empty bank to the Hadamard producer and a full bank to the
// IFFT controller, counting tiles per layer. All outputs come straight from flops.
module ifft_bank_sched
    import cnn_sched_pkg::*;
#(
    parameter int unsigned TILEW = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_layer_start,
    input  logic [TILEW-1:0] i_num_tiles,
    output logic             o_prod_start,
    output logic             o_prod_bank,
    input  logic             i_prod_done,
    output logic             o_ifftstart,
    output logic             o_cons_bank,
    input  logic             i_ifftdone,
    output logic [NBANK-1:0] o_bank_full,
    output logic             o_busy,
    output logic             o_layer_done,
    output logic             o_err_proto
);

    top_state_e       r_state;
    top_state_e       w_state_next;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [TILEW-1:0] r_num;
    logic [TILEW-1:0] r_issued;
    logic [TILEW-1:0] r_drained;
    logic             r_prod_start;
    logic             r_ifftstart;
    logic             r_busy;
    logic             r_layer_done;
    logic             r_err;

    bank_state_e      w_bank_state [NBANK];
    logic [NBANK-1:0] w_filling;
    logic [NBANK-1:0] w_draining;
    logic [NBANK-1:0] w_claim_wr;
    logic [NBANK-1:0] w_claim_rd;
    logic [NBANK-1:0] w_wr_done;
    logic [NBANK-1:0] w_rd_done;

    logic w_accept;
    logic w_prod_ok;
    logic w_ifft_ok;
    logic w_fire_prod;
    logic w_fire_cons;
    logic w_proto_err;
    logic w_busy_next;
    logic w_layer_done_next;

    assign w_accept    = i_layer_start && (r_state == TopIdle);
    assign w_prod_ok   = i_prod_done && (|w_filling);
    assign w_ifft_ok   = i_ifftdone && (|w_draining);
    assign w_proto_err = (i_prod_done && !(|w_filling))
                       || (i_ifftdone && !(|w_draining))
                       || (i_layer_start && (r_state != TopIdle));

    assign w_fire_prod = (r_state == TopRun) && (r_issued < r_num)
                       && (w_bank_state[r_wr_ptr] == BankEmpty) && !(|w_filling);
    assign w_fire_cons = (w_bank_state[r_rd_ptr] == BankFull) && !(|w_draining);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        localparam logic IDX = 1'(b);

        assign w_claim_wr[b] = w_fire_prod && (r_wr_ptr == IDX);
        assign w_wr_done[b]  = w_prod_ok && (r_wr_ptr == IDX);
        assign w_claim_rd[b] = w_fire_cons && (r_rd_ptr == IDX);
        assign w_rd_done[b]  = w_ifft_ok && (r_rd_ptr == IDX);

        spec_bank_tracker u_bank (
            .clk        (clk),
            .rstn       (rstn),
            .i_claim_wr (w_claim_wr[b]),
            .i_wr_done  (w_wr_done[b]),
            .i_claim_rd (w_claim_rd[b]),
            .i_rd_done  (w_rd_done[b]),
            .o_state    (w_bank_state[b])
        );

        assign w_filling[b]   = (w_bank_state[b] == BankFilling);
        assign w_draining[b]  = (w_bank_state[b] == BankDraining);
        assign o_bank_full[b] = bank_has_data(w_bank_state[b]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TopIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An empty layer still passes through RUN so layer_done lands two cycles after the start.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            TopIdle: if (w_accept) w_state_next = TopRun;
            TopRun:  if (r_drained == r_num) w_state_next = TopDone;
            TopDone: w_state_next = TopIdle;
            default: w_state_next = TopIdle;
        endcase
    end

    always_comb begin
        w_busy_next       = (w_state_next != TopIdle);
        w_layer_done_next = (w_state_next == TopDone);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_num        <= '0;
            r_issued     <= '0;
            r_drained    <= '0;
            r_prod_start <= 1'b0;
            r_ifftstart  <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_prod_start <= w_fire_prod;
            r_ifftstart  <= w_fire_cons;
            r_busy       <= w_busy_next;
            r_layer_done <= w_layer_done_next;
            r_err        <= (w_accept ? 1'b0 : r_err) | w_proto_err;
            if (w_prod_ok) r_wr_ptr <= ~r_wr_ptr;
            if (w_ifft_ok) r_rd_ptr <= ~r_rd_ptr;
            if (w_accept) begin
                r_num     <= i_num_tiles;
                r_issued  <= '0;
                r_drained <= '0;
            end else begin
                if (w_prod_ok) r_issued  <= r_issued + TILEW'(1);
                if (w_ifft_ok) r_drained <= r_drained + TILEW'(1);
            end
        end
    end

    assign o_prod_start = r_prod_start;
    assign o_prod_bank  = r_wr_ptr;
    assign o_ifftstart  = r_ifftstart;
    assign o_cons_bank  = r_rd_ptr;
    assign o_busy       = r_busy;
    assign o_layer_done = r_layer_done;
    assign o_err_proto  = r_err;

endmodule

// File: tb/tb_ifft_bank_sched.sv
// Directed bench for the IFFT bank scheduler: emulates producer and IFFT controller latencies.
module tb_ifft_bank_sched;

    localparam int unsigned TILEW = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_layer_start = 1'b0;
    logic [TILEW-1:0] i_num_tiles = '0;
    logic             i_prod_done = 1'b0;
    logic             i_ifftdone = 1'b0;
    logic             o_prod_start;
    logic             o_prod_bank;
    logic             o_ifftstart;
    logic             o_cons_bank;
    logic [1:0]       o_bank_full;
    logic             o_busy;
    logic             o_layer_done;
    logic             o_err_proto;
    logic [8:0]       w_outs;

    int n_vec = 0;
    int n_err = 0;
    int g_co  = 0;

    ifft_bank_sched #(.TILEW(TILEW)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_layer_start (i_layer_start),
        .i_num_tiles   (i_num_tiles),
        .o_prod_start  (o_prod_start),
        .o_prod_bank   (o_prod_bank),
        .i_prod_done   (i_prod_done),
        .o_ifftstart   (o_ifftstart),
        .o_cons_bank   (o_cons_bank),
        .i_ifftdone    (i_ifftdone),
        .o_bank_full   (o_bank_full),
        .o_busy        (o_busy),
        .o_layer_done  (o_layer_done),
        .o_err_proto   (o_err_proto)
    );

    always #5 clk = ~clk;

    assign w_outs = {o_prod_start, o_prod_bank, o_ifftstart, o_cons_bank, o_bank_full,
                     o_busy, o_layer_done, o_err_proto};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        i_layer_start = 1'b0;
        i_prod_done   = 1'b0;
        i_ifftdone    = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        tick();
    endtask

    // Cycle c is the sample point 1 time unit after the c-th edge following layer_start.
    task automatic run_layer(input int ntiles, input int pdly, input int cdly, input int inj_at,
                             input int abort_at, input logic exp_err, output logic aborted);
        int c = 1;
        int pcnt = 0, ccnt = 0, np = 0, nc = 0, nld = 0;
        int last_idone = -1, ld_cyc = -1, co_cyc = -1, co_bank = 0, pbank = 0;
        int first_ps = -1, first_is = -1;
        int pb[$];
        int cb[$];
        logic fin = 1'b0;
        aborted       = 1'b0;
        g_co          = 0;
        i_num_tiles   = TILEW'(ntiles);
        i_layer_start = 1'b1;
        tick();
        i_layer_start = 1'b0;
        check_eq("busy_at_t1", o_busy, 1);
        check_eq("err_clear_on_start", o_err_proto, 0);
        while (!fin) begin
            i_prod_done   = 1'b0;
            i_ifftdone    = 1'b0;
            i_layer_start = 1'b0;
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) i_prod_done = 1'b1;
            end
            if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) begin
                    i_ifftdone = 1'b1;
                    last_idone = c;
                end
            end
            if (i_prod_done && i_ifftdone) begin
                co_cyc  = c;
                co_bank = pbank;
                g_co++;
            end
            if (co_cyc >= 0 && c == co_cyc + 1)
                check_eq("dual_done_banks", o_bank_full, 32'(1) << co_bank);
            if (co_cyc >= 0 && c == co_cyc + 2)
                check_eq("dual_done_ifftstart", {o_ifftstart, o_cons_bank}, {1'b1, 1'(co_bank)});
            if (o_prod_start) begin
                if (np == 0) first_ps = c;
                if (np == 1) check_eq("overlap_bank_full", o_bank_full, 2'b01);
                pb.push_back(int'(o_prod_bank));
                pbank = int'(o_prod_bank);
                pcnt  = pdly;
                np++;
            end
            if (o_ifftstart) begin
                if (nc == 0) first_is = c;
                cb.push_back(int'(o_cons_bank));
                ccnt = cdly;
                nc++;
            end
            if (o_layer_done) begin
                nld++;
                ld_cyc = c;
            end
            if (c == inj_at) begin
                i_layer_start = 1'b1;
                i_num_tiles   = 8'd5;
            end
            if (inj_at >= 0 && c == inj_at + 1) check_eq("err_on_busy_start", o_err_proto, 1);
            if (c == abort_at) begin
                i_prod_done   = 1'b0;
                i_ifftdone    = 1'b0;
                i_layer_start = 1'b0;
                aborted       = 1'b1;
                return;
            end
            if (ld_cyc >= 0 && c == ld_cyc + 1) begin
                check_eq("busy_low_after_done", o_busy, 0);
                fin = 1'b1;
            end else if (c >= 400) begin
                check_eq("layer_done_seen", (ld_cyc >= 0), 1);
                fin = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        i_prod_done = 1'b0;
        i_ifftdone  = 1'b0;
        check_eq("layer_done_count", nld, 1);
        check_eq("prod_start_count", np, ntiles);
        check_eq("ifftstart_count", nc, ntiles);
        foreach (pb[i]) check_eq($sformatf("prod_bank_%0d", i), pb[i], i % 2);
        foreach (cb[i]) check_eq($sformatf("cons_bank_%0d", i), cb[i], i % 2);
        if (ntiles == 0) begin
            check_eq("empty_layer_done_lat", ld_cyc, 2);
        end else begin
            check_eq("layer_done_lat", ld_cyc - last_idone, 2);
            check_eq("first_prod_start_lat", first_ps, 2);
            check_eq("first_ifftstart_lat", first_is, first_ps + pdly + 2);
        end
        check_eq("err_proto_end", o_err_proto, exp_err);
    endtask

    initial begin
        logic ab;
        logic bad;
        do_reset();
        check_eq("reset_outputs", w_outs, 0);

        // Three tiles, producer 10 cycles, IFFT 20 cycles: fill of bank 1 overlaps drain of bank 0.
        run_layer(3, 10, 20, -1, -1, 1'b0, ab);
        check_eq("t1_no_dual_done", g_co, 0);

        do_reset();
        run_layer(0, 10, 10, -1, -1, 1'b0, ab);

        // Equal latencies line up prod_done and ifftdone twice.
        do_reset();
        run_layer(3, 10, 10, -1, -1, 1'b0, ab);
        check_eq("t4_dual_done_events", g_co, 2);

        // Protocol errors while idle, then a start while busy that must be ignored.
        do_reset();
        i_ifftdone = 1'b1;
        tick();
        i_ifftdone = 1'b0;
        check_eq("err_ifftdone_idle", o_err_proto, 1);
        i_prod_done = 1'b1;
        tick();
        i_prod_done = 1'b0;
        check_eq("idle_after_errs", {o_busy, o_bank_full, o_prod_start, o_ifftstart}, 0);
        check_eq("err_sticky", o_err_proto, 1);
        run_layer(1, 10, 10, 5, -1, 1'b1, ab);

        // Reset in the middle of draining tile 2.
        do_reset();
        run_layer(3, 10, 20, -1, 40, 1'b0, ab);
        check_eq("abort_reached", ab, 1);
        check_eq("pre_reset_state", {o_busy, o_cons_bank, o_bank_full}, 4'b1110);
        #1 rstn = 1'b0;
        #1 check_eq("async_reset_outputs", w_outs, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (w_outs !== 9'd0) bad = 1'b1;
        end
        check_eq("quiet_after_reset", bad, 0);
        run_layer(2, 10, 20, -1, -1, 1'b0, ab);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
